// File: rtl/wb_switch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_switch_pkg
// Brief   : Shared types, Wishbone field widths and helpers for the
//           Wishbone arbiter/switch and its round-robin arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package wb_switch_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  localparam int WB_CTI_W = 3;
  localparam int WB_BTE_W = 2;

  // Switch ownership state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } sw_state_t;

  // Width of an index able to address n entries; never less than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 6; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

  // True when addr falls in the window of base with the low span bits ignored.
  function automatic logic addr_match(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [4:0]  span);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << span;
    return (addr & mask) == (base & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_rr_arbiter
// Brief   : Combinational round-robin picker. Returns a one-hot grant for
//           the first asserted request at or after ptr, wrapping to 0.
// Revision: 1.0 - initial release
// ============================================================================
module wb_rr_arbiter
  import wb_switch_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]             req,
  input  logic [idx_width(N)-1:0]  ptr,
  output logic [N-1:0]             grant
);

  // Scan from ptr upward (mod N); first hit wins.
  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter_switch.sv
`default_nettype none
// ============================================================================
// Module  : wb_arbiter_switch
// Brief   : N-master / M-slave Wishbone switch. One master owns the shared
//           slave bus at a time (round-robin), the address is decoded to a
//           slave window, unmapped accesses are answered with a one-cycle
//           error. Optional bus watchdog: define WB_SWITCH_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module wb_arbiter_switch
  import wb_switch_pkg::*;
#(
  parameter int                    NMASTERS       = 2,
  parameter int                    NSLAVES        = 2,
  parameter logic [NSLAVES*32-1:0] BASE_ADDR      = {32'h1000_0000, 32'h8000_0000},
  parameter logic [NSLAVES*5-1:0]  ADDR_WIDTH     = {5'd8, 5'd24},
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  // master requests
  input  logic [NMASTERS*WB_ADR_W-1:0]   master_addr,
  input  logic [NMASTERS*WB_DAT_W-1:0]   master_wdata,
  input  logic [NMASTERS*WB_SEL_W-1:0]   master_sel,
  input  logic [NMASTERS-1:0]            master_we,
  input  logic [NMASTERS-1:0]            master_cyc,
  input  logic [NMASTERS-1:0]            master_stb,
  input  logic [NMASTERS*WB_CTI_W-1:0]   master_cti,
  input  logic [NMASTERS*WB_BTE_W-1:0]   master_bte,
  // master responses
  output logic [NMASTERS*WB_DAT_W-1:0]   master_rdata,
  output logic [NMASTERS-1:0]            master_ack,
  output logic [NMASTERS-1:0]            master_err,
  // shared slave request bus
  output logic [WB_ADR_W-1:0]            slave_addr,
  output logic [WB_DAT_W-1:0]            slave_wdata,
  output logic [WB_SEL_W-1:0]            slave_sel,
  output logic                           slave_we,
  output logic [WB_CTI_W-1:0]            slave_cti,
  output logic [WB_BTE_W-1:0]            slave_bte,
  // per-slave strobes and responses
  output logic [NSLAVES-1:0]             slave_cyc,
  output logic [NSLAVES-1:0]             slave_stb,
  input  logic [NSLAVES*WB_DAT_W-1:0]    slave_rdata,
  input  logic [NSLAVES-1:0]             slave_ack,
  input  logic [NSLAVES-1:0]             slave_err
);

  localparam int MIDXW = idx_width(NMASTERS);
  localparam int SIDXW = idx_width(NSLAVES);

  generate
    if (NMASTERS < 1 || NMASTERS > 8 || NSLAVES < 1 || NSLAVES > 16 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
      $error("wb_arbiter_switch: parameter out of range");
    end
  endgenerate

  sw_state_t         state, state_nxt;
  logic [MIDXW-1:0]  rr_ptr, rr_ptr_nxt;
  logic [MIDXW-1:0]  gnt_idx, gnt_idx_nxt;
  logic [NMASTERS-1:0] arb_gnt;
  logic [MIDXW-1:0]  arb_idx;

  logic [WB_ADR_W-1:0] g_addr;
  logic                g_cyc, g_stb;
  logic                dec_hit;
  logic [SIDXW-1:0]    dec_idx;
  logic                timeout;

  wb_rr_arbiter #(.N(NMASTERS)) u_arb (
    .req   (master_cyc),
    .ptr   (rr_ptr),
    .grant (arb_gnt)
  );

  // One-hot grant from the arbiter to a master index.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NMASTERS; i++) begin
      if (arb_gnt[i]) arb_idx = MIDXW'(i);
    end
  end

  assign g_addr = master_addr[WB_ADR_W*gnt_idx +: WB_ADR_W];
  assign g_cyc  = master_cyc[gnt_idx];
  assign g_stb  = master_stb[gnt_idx];

  // Address decode of the granted master; lowest matching slave wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (addr_match(g_addr, BASE_ADDR[32*i +: 32], ADDR_WIDTH[5*i +: 5])) begin
        dec_hit = 1'b1;
        dec_idx = SIDXW'(i);
      end
    end
  end

`ifdef WB_SWITCH_TIMEOUT_EN
  logic [15:0] wd, wd_nxt;
  logic        wd_tick;

  // The ERR cycle itself is the TIMEOUT_CYCLES-th stb cycle, so the FSM is
  // told one cycle ahead (counter holds completed stall cycles).
  assign wd_tick = (state == ST_BUSY) && g_cyc && g_stb && dec_hit &&
                   !slave_ack[dec_idx] && !slave_err[dec_idx];
  assign timeout = wd_tick && (({1'b0, wd} + 17'd2) >= 17'(TIMEOUT_CYCLES));
  assign wd_nxt  = (wd_tick && !timeout) ? wd + 16'd1 : 16'd0;

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wd <= 16'd0;
    else      wd <= wd_nxt;
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state, grant capture and round-robin pointer advance.
  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    gnt_idx_nxt = gnt_idx;
    case (state)
      ST_IDLE: begin
        if (|master_cyc) begin
          gnt_idx_nxt = arb_idx;
          state_nxt   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!g_cyc) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = (gnt_idx == MIDXW'(NMASTERS - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (g_stb && !dec_hit) begin
          state_nxt = ST_ERR;
        end else if (timeout) begin
          state_nxt = ST_ERR;
        end
      end
      ST_ERR:  state_nxt = ST_BUSY;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, pointer and grant registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      gnt_idx <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_ptr_nxt;
      gnt_idx <= gnt_idx_nxt;
    end
  end

  // Bus muxing and response routing; everything is quiet outside ownership.
  always_comb begin
    slave_addr   = '0;
    slave_wdata  = '0;
    slave_sel    = '0;
    slave_we     = 1'b0;
    slave_cti    = '0;
    slave_bte    = '0;
    slave_cyc    = '0;
    slave_stb    = '0;
    master_rdata = '0;
    master_ack   = '0;
    master_err   = '0;
    if (state != ST_IDLE) begin
      slave_addr  = g_addr;
      slave_wdata = master_wdata[WB_DAT_W*gnt_idx +: WB_DAT_W];
      slave_sel   = master_sel[WB_SEL_W*gnt_idx +: WB_SEL_W];
      slave_we    = master_we[gnt_idx];
      slave_cti   = master_cti[WB_CTI_W*gnt_idx +: WB_CTI_W];
      slave_bte   = master_bte[WB_BTE_W*gnt_idx +: WB_BTE_W];
    end
    if (state == ST_BUSY && dec_hit) begin
      slave_cyc[dec_idx] = g_cyc;
      slave_stb[dec_idx] = g_stb;
      master_ack[gnt_idx] = slave_ack[dec_idx] & g_cyc & g_stb;
      master_err[gnt_idx] = slave_err[dec_idx] & g_cyc & g_stb;
      master_rdata[WB_DAT_W*gnt_idx +: WB_DAT_W] = slave_rdata[WB_DAT_W*dec_idx +: WB_DAT_W];
    end
    if (state == ST_ERR) begin
      master_err[gnt_idx] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_switch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_wb_arbiter_switch
// Brief   : Directed self-checking bench for wb_arbiter_switch (2 masters,
//           2 slaves, default address map). Watchdog scenario is exercised
//           when WB_SWITCH_TIMEOUT_EN is defined, stall scenario otherwise.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_arbiter_switch;

  localparam int NM = 2;
  localparam int NS = 2;
`ifdef WB_SWITCH_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [NM*32-1:0] master_addr, master_wdata;
  logic [NM*4-1:0]  master_sel;
  logic [NM-1:0]    master_we, master_cyc, master_stb;
  logic [NM*3-1:0]  master_cti;
  logic [NM*2-1:0]  master_bte;
  logic [NM*32-1:0] master_rdata;
  logic [NM-1:0]    master_ack, master_err;
  logic [31:0]      slave_addr, slave_wdata;
  logic [3:0]       slave_sel;
  logic             slave_we;
  logic [2:0]       slave_cti;
  logic [1:0]       slave_bte;
  logic [NS-1:0]    slave_cyc, slave_stb;
  logic [NS*32-1:0] slave_rdata;
  logic [NS-1:0]    slave_ack, slave_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_arbiter_switch #(
    .NMASTERS       (NM),
    .NSLAVES        (NS),
    .BASE_ADDR      ({32'h1000_0000, 32'h8000_0000}),
    .ADDR_WIDTH     ({5'd8, 5'd24}),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .master_addr  (master_addr),
    .master_wdata (master_wdata),
    .master_sel   (master_sel),
    .master_we    (master_we),
    .master_cyc   (master_cyc),
    .master_stb   (master_stb),
    .master_cti   (master_cti),
    .master_bte   (master_bte),
    .master_rdata (master_rdata),
    .master_ack   (master_ack),
    .master_err   (master_err),
    .slave_addr   (slave_addr),
    .slave_wdata  (slave_wdata),
    .slave_sel    (slave_sel),
    .slave_we     (slave_we),
    .slave_cti    (slave_cti),
    .slave_bte    (slave_bte),
    .slave_cyc    (slave_cyc),
    .slave_stb    (slave_stb),
    .slave_rdata  (slave_rdata),
    .slave_ack    (slave_ack),
    .slave_err    (slave_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_m(input int m, input logic [31:0] a, input logic we,
                       input logic cs, input logic [2:0] cti);
    master_addr[32*m +: 32]  = a;
    master_wdata[32*m +: 32] = a ^ 32'h5A5A_5A5A;
    master_sel[4*m +: 4]     = 4'hF;
    master_we[m]             = we;
    master_cyc[m]            = cs;
    master_stb[m]            = cs;
    master_cti[3*m +: 3]     = cti;
    master_bte[2*m +: 2]     = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_m(0, 32'h8000_0000, 1'b1, 1'b1, 3'b000);
    mid();
    checks++;
    if ({slave_cyc, slave_stb, master_ack, master_err} !== 8'h00) begin
      failures++;
      $display("FAIL reset_strobes got=%b want=00000000", {slave_cyc, slave_stb, master_ack, master_err});
    end
    checks++;
    if ({slave_addr, slave_we, master_rdata} !== 97'd0) begin
      failures++;
      $display("FAIL reset_bus got addr=%h we=%b rdata=%h want all zero", slave_addr, slave_we, master_rdata);
    end
    tick();
    set_m(0, 32'h0, 1'b0, 1'b0, 3'b000);
    rst = 1'b1;
  endtask

  task automatic test_read();
    tick();
    set_m(0, 32'h8000_0010, 1'b0, 1'b1, 3'b000);
    mid();
    checks++;
    if (slave_cyc !== 2'b00) begin
      failures++;
      $display("FAIL read_latency got slave_cyc=%b want=00", slave_cyc);
    end
    tick(); mid();
    checks++;
    if (slave_stb !== 2'b01 || slave_addr !== 32'h8000_0010 || master_ack !== 2'b00) begin
      failures++;
      $display("FAIL read_strobe got stb=%b addr=%h ack=%b want 01 80000010 00", slave_stb, slave_addr, master_ack);
    end
    tick();
    slave_ack = 2'b01;
    slave_rdata = {32'h1111_2222, 32'hDEAD_BEEF};
    mid();
    checks++;
    if (master_ack !== 2'b01 || master_rdata !== {32'h0, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL read_ack got ack=%b rdata=%h want 01 00000000deadbeef", master_ack, master_rdata);
    end
    tick();
    slave_ack = 2'b00;
    set_m(0, 32'h0, 1'b0, 1'b0, 3'b000);
    mid();
    checks++;
    if (master_ack !== 2'b00) begin
      failures++;
      $display("FAIL read_ack_once got ack=%b want=00", master_ack);
    end
  endtask

  task automatic test_unmapped();
    tick();
    set_m(1, 32'h2000_0000, 1'b1, 1'b1, 3'b000);
    tick(); mid();
    checks++;
    if (slave_cyc !== 2'b00 || master_err !== 2'b00) begin
      failures++;
      $display("FAIL unmapped_busy got cyc=%b err=%b want 00 00", slave_cyc, master_err);
    end
    tick(); mid();
    checks++;
    if (master_err !== 2'b10 || slave_cyc !== 2'b00 || slave_stb !== 2'b00 || master_ack !== 2'b00) begin
      failures++;
      $display("FAIL unmapped_err got err=%b cyc=%b stb=%b ack=%b want 10 00 00 00", master_err, slave_cyc, slave_stb, master_ack);
    end
    tick();
    set_m(1, 32'h0, 1'b0, 1'b0, 3'b000);
    mid();
    checks++;
    if (master_err !== 2'b00) begin
      failures++;
      $display("FAIL unmapped_err_once got err=%b want=00", master_err);
    end
  endtask

  task automatic test_round_robin();
    tick();
    set_m(0, 32'h8000_0100, 1'b0, 1'b1, 3'b000);
    set_m(1, 32'h8000_0200, 1'b0, 1'b1, 3'b000);
    tick();
    slave_ack = 2'b01;
    mid();
    checks++;
    if (slave_addr !== 32'h8000_0100 || master_ack !== 2'b01) begin
      failures++;
      $display("FAIL rr_first got addr=%h ack=%b want 80000100 01", slave_addr, master_ack);
    end
    tick();
    slave_ack = 2'b00;
    set_m(0, 32'h0, 1'b0, 1'b0, 3'b000);
    mid();
    checks++;
    if ({master_ack, master_err, slave_cyc} !== 6'b0) begin
      failures++;
      $display("FAIL rr_holdoff got ack=%b err=%b cyc=%b want all zero", master_ack, master_err, slave_cyc);
    end
    tick(); mid();
    tick();
    slave_ack = 2'b01;
    mid();
    checks++;
    if (slave_addr !== 32'h8000_0200 || master_ack !== 2'b10) begin
      failures++;
      $display("FAIL rr_second got addr=%h ack=%b want 80000200 10", slave_addr, master_ack);
    end
    tick();
    slave_ack = 2'b00;
    set_m(1, 32'h0, 1'b0, 1'b0, 3'b000);
    tick();
    set_m(0, 32'h8000_0100, 1'b0, 1'b1, 3'b000);
    set_m(1, 32'h8000_0200, 1'b0, 1'b1, 3'b000);
    tick();
    slave_ack = 2'b01;
    mid();
    checks++;
    if (slave_addr !== 32'h8000_0100 || master_ack !== 2'b01) begin
      failures++;
      $display("FAIL rr_third got addr=%h ack=%b want 80000100 01", slave_addr, master_ack);
    end
    tick();
    slave_ack = 2'b00;
    set_m(0, 32'h0, 1'b0, 1'b0, 3'b000);
    set_m(1, 32'h0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic test_back_to_back();
    tick();
    set_m(0, 32'h8000_0020, 1'b1, 1'b1, 3'b000);
    tick();
    slave_ack = 2'b01;
    mid();
    checks++;
    if (master_ack !== 2'b01 || slave_we !== 1'b1 || slave_wdata !== (32'h8000_0020 ^ 32'h5A5A_5A5A)) begin
      failures++;
      $display("FAIL b2b_first got ack=%b we=%b wdata=%h want 01 1 %h", master_ack, slave_we, slave_wdata, 32'h8000_0020 ^ 32'h5A5A_5A5A);
    end
    tick();
    slave_ack = 2'b00;
    set_m(0, 32'h8000_0020, 1'b1, 1'b0, 3'b000);
    tick();
    set_m(0, 32'h8000_0024, 1'b1, 1'b1, 3'b000);
    mid();
    checks++;
    if (slave_cyc !== 2'b00) begin
      failures++;
      $display("FAIL b2b_idle got cyc=%b want=00", slave_cyc);
    end
    tick();
    slave_err = 2'b01;
    mid();
    checks++;
    if (slave_cyc !== 2'b01 || slave_addr !== 32'h8000_0024 || master_err !== 2'b01 || master_ack !== 2'b00) begin
      failures++;
      $display("FAIL b2b_regrant got cyc=%b addr=%h err=%b ack=%b want 01 80000024 01 00", slave_cyc, slave_addr, master_err, master_ack);
    end
    tick();
    slave_err = 2'b00;
    set_m(0, 32'h0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic test_reset_mid_burst();
    tick();
    set_m(0, 32'h8000_0040, 1'b0, 1'b1, 3'b010);
    tick();
    set_m(1, 32'h8000_0300, 1'b0, 1'b1, 3'b000);
    slave_ack = 2'b01;
    mid();
    checks++;
    if (slave_cti !== 3'b010 || slave_cyc !== 2'b01 || master_ack !== 2'b01) begin
      failures++;
      $display("FAIL burst_beat1 got cti=%b cyc=%b ack=%b want 010 01 01", slave_cti, slave_cyc, master_ack);
    end
    tick();
    master_addr[31:0] = 32'h8000_0044;
    mid();
    checks++;
    if (slave_addr !== 32'h8000_0044 || master_ack !== 2'b01) begin
      failures++;
      $display("FAIL burst_hold got addr=%h ack=%b want 80000044 01", slave_addr, master_ack);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({slave_cyc, slave_stb, master_ack} !== 6'b0) begin
      failures++;
      $display("FAIL reset_async got cyc=%b stb=%b ack=%b want all zero", slave_cyc, slave_stb, master_ack);
    end
    set_m(0, 32'h0, 1'b0, 1'b0, 3'b000);
    set_m(1, 32'h0, 1'b0, 1'b0, 3'b000);
    slave_ack = 2'b00;
    tick();
    rst = 1'b1;
    slave_ack = 2'b01;
    mid();
    checks++;
    if (master_ack !== 2'b00 || slave_cyc !== 2'b00) begin
      failures++;
      $display("FAIL reset_no_stray got ack=%b cyc=%b want 00 00", master_ack, slave_cyc);
    end
    tick();
    slave_ack = 2'b00;
    set_m(0, 32'h8000_0050, 1'b0, 1'b1, 3'b000);
    set_m(1, 32'h8000_0350, 1'b0, 1'b1, 3'b000);
    tick(); mid();
    checks++;
    if (slave_addr !== 32'h8000_0050) begin
      failures++;
      $display("FAIL reset_rr_ptr got addr=%h want 80000050", slave_addr);
    end
    tick();
    set_m(0, 32'h0, 1'b0, 1'b0, 3'b000);
    set_m(1, 32'h0, 1'b0, 1'b0, 3'b000);
  endtask

`ifdef WB_SWITCH_TIMEOUT_EN
  task automatic test_timeout();
    tick();
    set_m(0, 32'h1000_0004, 1'b0, 1'b1, 3'b000);
    for (int k = 1; k < 16; k++) begin
      tick(); mid();
      checks++;
      if (slave_stb !== 2'b10 || master_err !== 2'b00) begin
        failures++;
        $display("FAIL timeout_wait cycle=%0d got stb=%b err=%b want 10 00", k, slave_stb, master_err);
      end
    end
    tick(); mid();
    checks++;
    if (master_err !== 2'b01 || slave_stb !== 2'b00 || slave_cyc !== 2'b00) begin
      failures++;
      $display("FAIL timeout_err got err=%b stb=%b cyc=%b want 01 00 00", master_err, slave_stb, slave_cyc);
    end
    tick();
    set_m(0, 32'h0, 1'b0, 1'b0, 3'b000);
    mid();
    checks++;
    if (master_err !== 2'b00) begin
      failures++;
      $display("FAIL timeout_err_once got err=%b want=00", master_err);
    end
  endtask
`else
  task automatic test_stall();
    tick();
    set_m(0, 32'h1000_0004, 1'b0, 1'b1, 3'b000);
    for (int k = 1; k <= 40; k++) begin
      tick(); mid();
      checks++;
      if (slave_stb !== 2'b10 || master_err !== 2'b00) begin
        failures++;
        $display("FAIL stall cycle=%0d got stb=%b err=%b want 10 00", k, slave_stb, master_err);
      end
    end
    tick();
    set_m(0, 32'h0, 1'b0, 1'b0, 3'b000);
    mid();
    checks++;
    if (slave_stb !== 2'b00) begin
      failures++;
      $display("FAIL stall_release got stb=%b want=00", slave_stb);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    master_addr = '0; master_wdata = '0; master_sel = '0; master_we = '0;
    master_cyc = '0; master_stb = '0; master_cti = '0; master_bte = '0;
    slave_rdata = '0; slave_ack = '0; slave_err = '0;
    test_reset();
    test_read();
    test_unmapped();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_burst();
`ifdef WB_SWITCH_TIMEOUT_EN
    test_timeout();
`else
    test_stall();
`endif
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter_switch.md
WB_ARBITER_SWITCH -- requirements
Module: wb_arbiter_switch

Interface
REQ-001 Parameter NMASTERS, default 2: number of Wishbone masters; range 1-8.
REQ-002 Parameter NSLAVES, default 2: number of slaves; range 1-16.
REQ-003 Parameter BASE_ADDR, default {32'h1000_0000, 32'h8000_0000}: packed NSLAVES x 32 slave base addresses; slave i occupies bits [32*i+31:32*i].
REQ-004 Parameter ADDR_WIDTH, default {5'd8, 5'd24}: packed NSLAVES x 5 decoded span width per slave.
REQ-005 Parameter TIMEOUT_CYCLES, default 255: bus watchdog limit, 1-65535.
REQ-006 Port clk, input, 1: single clock; one clock and one reset; reset is asynchronous and active-low.
REQ-007 Port rst, input, 1: asynchronous active-low reset.
REQ-008 Ports master_addr/master_wdata (in, NMASTERS*32), master_sel (in, NMASTERS*4), master_we/master_cyc/master_stb (in, NMASTERS), master_cti (in, NMASTERS*3), master_bte (in, NMASTERS*2): packed master requests.
REQ-009 Ports master_rdata (out, NMASTERS*32), master_ack/master_err (out, NMASTERS): packed master responses.
REQ-010 Ports slave_addr/slave_wdata (out, 32), slave_sel (out, 4), slave_we (out, 1), slave_cti (out, 3), slave_bte (out, 2): shared slave request bus.
REQ-011 Ports slave_cyc/slave_stb (out, NSLAVES), slave_rdata (in, NSLAVES*32), slave_ack/slave_err (in, NSLAVES): per-slave strobes and responses.

Function
REQ-012 Slave i SHALL decode when addr[31:ADDR_WIDTH_i] == BASE_ADDR_i[31:ADDR_WIDTH_i]; multiple hits select the lowest index.
REQ-013 FSM states SHALL be IDLE, BUSY, ERR.
REQ-014 IDLE: on any master_cyc high, SHALL register grant to the first requesting master at or after rr_ptr (wrapping NMASTERS-1 -> 0) and enter BUSY next cycle; grant latency exactly 1 cycle.
REQ-015 BUSY: shared bus SHALL carry granted master's addr/wdata/sel/we/cti/bte; slave_cyc/slave_stb of decoded slave SHALL follow granted master's cyc/stb combinationally; all other slave_cyc/stb 0.
REQ-016 BUSY with granted stb high and no slave decoded: SHALL enter ERR, issue master_err for exactly one cycle, no slave strobed, then return to BUSY.
REQ-017 Slave ack/err/rdata SHALL route only to the granted master; non-granted masters see ack=0, err=0, rdata=0.
REQ-018 Grant SHALL be held while granted master_cyc stays high (burst/locked cycles); cyc low in BUSY -> IDLE, rr_ptr = granted+1 mod NMASTERS.
REQ-019 Requests from non-granted masters SHALL be held off (no ack/err) until arbitration; no request dropped.
REQ-020 Single requester SHALL be re-granted back-to-back with one idle cycle between ownerships.

Reset
REQ-021 While rst low: state=IDLE, rr_ptr=0, grant cleared, watchdog=0, all slave_cyc/stb=0, all master_ack/err=0, shared bus outputs 0.
REQ-022 Reset asserted mid-transaction SHALL drop slave_cyc/stb immediately (async); no ack delivered after deassertion for the aborted cycle.

Configuration
REQ-023 Macro WB_SWITCH_TIMEOUT_EN: when defined, a 16-bit watchdog counts cycles with granted stb high and no slave ack/err, clears on ack/err or stb low; on reaching TIMEOUT_CYCLES it SHALL drive master_err one cycle via ERR and force slave_cyc/stb low that cycle. When undefined, no counter exists and a silent slave stalls the bus indefinitely.

Structure
REQ-024 Shared package wb_switch_pkg SHALL hold the FSM state enum, Wishbone field widths (SEL=4, CTI=3, BTE=2) and the rr-arbiter index width function.
REQ-025 Sub-module wb_rr_arbiter (request vector, pointer -> one-hot grant) SHALL be separate; decode and muxing stay in wb_arbiter_switch.

Verification
REQ-026 M0 reads 0x8000_0010, slave0 acks 2 cycles later with 0xDEAD_BEEF -> master_rdata[31:0]=0xDEAD_BEEF, master_ack[0] one cycle, slave_stb=2'b01.
REQ-027 M0 and M1 assert cyc same cycle, rr_ptr=0 -> M0 granted first; after M0 cyc drop, M1 granted; next simultaneous pair -> M0 again.
REQ-028 M1 writes 0x2000_0000 (unmapped) -> master_err[1] one cycle, slave_cyc=0, slave_we never seen by any slave.
REQ-029 WB_SWITCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave1 never acks access to 0x1000_0004 -> master_err[0] on cycle 16 of stb, slave_stb[1] low that cycle.
REQ-030 rst pulsed low during M0 burst (cti=3'b010) -> slave_cyc all 0 asynchronously, state IDLE, rr_ptr=0, no stray ack after release.
